ahb_sram_slave: RTL
===================

# ahb_sram_slave

AHB-Lite responder with an internal register-array memory; the endpoint on one slave port of the generated AHB bus. It sits behind a bus slave port, is driven by that port's `mas_send_type` payload and `hsel`, and returns a `slv_send_type` payload. It supports pipelined address/data phases, programmable wait states, and byte/halfword/word writes. It returns a two-cycle ERROR response for illegal transfers.

## Interface
- `DEPTH`, 256: memory size in 32-bit words. Power of two, 16..4096.
- `WAIT_CYCLES`, 0: wait states inserted in every OKAY data phase, 0..15.
- `ADDR_BASE`, 32'h0: byte address of word 0. Must be DEPTH*4 aligned.
- `hclk` input 1: bus clock, rising edge.
- `hreset_n` input 1: asynchronous, active-low reset.
- `hsel` input 1: slave select from the bus arbiter.
- `slave_in` input 78 (`mas_send_type`): haddr[31:0], hwdata[31:0], htrans[1:0], hburst[2:0], hsize[2:0], hwrite, hprot[3:0], hmastlock.
- `slave_out` output 34 (`slv_send_type`): hreadyout, hrdata[31:0], hresp (0=OKAY, 1=ERROR).

## Operation
- Address phase accepted on a rising edge when `hsel=1`, htrans is NONSEQ(2) or SEQ(3), and hreadyout=1. The block then latches the address, size and write flag.
- IDLE(0), BUSY(1) or `hsel=0` with hreadyout=1: no transfer, no state change, and the next cycle is a zero-wait OKAY.
- hburst, hprot and hmastlock are ignored; every beat is decoded independently.
- Legality checks at accept time:
  - Word index = (haddr-ADDR_BASE)>>2. An index ≥ DEPTH, or haddr < ADDR_BASE, is out of range and gets ERROR.
  - hsize > 2 gets ERROR.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0. A counter loads WAIT_CYCLES-1 and decrements; the FSM goes to DATA at count 0.
  - DATA: hreadyout=1, hresp=0.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- FSM transitions on an accepted legal transfer: WAIT if WAIT_CYCLES>0, else DATA.
- FSM transitions on an accepted illegal transfer: ERR1, then ERR2.
- From DATA or ERR2:
  - A new accept goes to the state required by that transfer.
  - Otherwise the FSM returns to IDLE.
- Write commit: on the rising edge ending the final (hreadyout=1) data-phase cycle of an OKAY write, from hwdata.
  - Lanes are little-endian: byte at addr[1:0]=k uses hwdata[8k+7:8k].
  - Halfword uses lanes {2·addr[1]+1, 2·addr[1]}.
  - Word uses all lanes.
  - ERROR transfers never write.
- Read data: hrdata = mem[index] only in the final DATA cycle of an OKAY read, and 0 in every other cycle.
- A read immediately following a write to the same word returns the newly written data.
- Memory contents are not reset.

## Timing
- Reset (asynchronous, immediate): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, counter=0.
- Read latency: data is valid WAIT_CYCLES+1 cycles after the address-phase edge.
- Data phase length: WAIT_CYCLES+1 cycles for OKAY, exactly 2 cycles for ERROR.
- The next transfer's address phase overlaps the current final data cycle, so WAIT_CYCLES=0 sustains one transfer per cycle.
- During WAIT and ERR1, address/control inputs are not sampled. A master that drives IDLE during ERR1 causes no new transfer.
- Reset asserted mid-WAIT: the pending write is dropped and outputs reach reset values without waiting for a clock.

## Configuration
- `AHB_SRAM_SLAVE_MISALIGN_ERR_EN` defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 gets the ERR1/ERR2 response and no write.
- Undefined: misaligned low address bits are masked (halfword clears addr[0], word clears addr[1:0]) and the transfer completes OKAY.

## Test plan
- WAIT_CYCLES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Required: hreadyout=1 on every cycle, and hrdata=0xDEADBEEF one cycle after the read address phase.
- Byte write 0xA5 to 0x11 after the test above, then word read of 0x10. Required: 0xDEADA5EF. Halfword write 0x1234 to 0x12 then read 0x10 gives 0x1234A5EF.
- WAIT_CYCLES=3: read 0x10. Required: hreadyout=0 for 3 cycles, then hreadyout=1 with data on the 4th cycle. A SEQ presented during the waits is not accepted until that 4th cycle.
- DEPTH=256, write to haddr=0x400. Required: cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1. A subsequent read of 0x0 is unchanged.
- Word write to 0x2. With the macro: ERROR response, no write. Without: word 0x0 is written, OKAY.
- Assert hreset_n=0 in the second of 3 wait cycles of a write. Required: outputs go to 1/0/0 asynchronously and the target word is not modified.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a register-array memory with programmable wait states.
// Define AHB_SRAM_SLAVE_MISALIGN_ERR_EN to turn misaligned halfword/word accesses into ERROR responses.
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic [77:0] slave_in,
    output logic [33:0] slave_out
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_e;

    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lo;
            2'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

    logic [31:0]   haddr_s, hwdata_s, off_s;
    logic [1:0]    htrans_s;
    logic [2:0]    hsize_s;
    logic          hwrite_s;
    logic          unused_ctrl_s;
    logic          accept_s, range_err_s, align_err_s, illegal_s, wr_en_s;
    logic [1:0]    new_lo_s;
    logic [AW-1:0] new_idx_s, rd_idx_s;
    logic [31:0]   wr_word_s, rd_word_s;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lo_q, lo_d, size_q, size_d;
    logic          write_q, write_d;
    logic          hreadyout_q, hreadyout_d, hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic [31:0]   mem_q [DEPTH];

    assign haddr_s       = slave_in[77:46];
    assign hwdata_s      = slave_in[45:14];
    assign htrans_s      = slave_in[13:12];
    assign hsize_s       = slave_in[8:6];
    assign hwrite_s      = slave_in[5];
    // hburst, hprot and hmastlock carry no meaning for this endpoint
    assign unused_ctrl_s = ^{slave_in[11:9], slave_in[4:0]};
    assign slave_out     = {hreadyout_q, hrdata_q, hresp_q};

    // Address decode and legality of the transfer presented on the bus this cycle
    always_comb begin
        off_s       = haddr_s - ADDR_BASE;
        accept_s    = hsel && htrans_s[1] && hreadyout_q;
        range_err_s = (haddr_s < ADDR_BASE) || ({2'b00, off_s[31:2]} >= 32'(DEPTH));
        new_idx_s   = off_s[AW+1:2];
`ifdef AHB_SRAM_SLAVE_MISALIGN_ERR_EN
        align_err_s = ((hsize_s == 3'd1) && off_s[0]) || ((hsize_s == 3'd2) && (off_s[1:0] != 2'b00));
        new_lo_s    = off_s[1:0];
`else
        align_err_s = 1'b0;
        if (hsize_s == 3'd1) begin
            new_lo_s = {off_s[1], 1'b0};
        end else if (hsize_s == 3'd2) begin
            new_lo_s = 2'b00;
        end else begin
            new_lo_s = off_s[1:0];
        end
`endif
        illegal_s = range_err_s || (hsize_s > 3'd2) || align_err_s;
    end

    // Write merge and read path; a write finishing this edge is forwarded to a read sampled on it
    always_comb begin
        wr_en_s   = (state_q == S_DATA) && write_q;
        wr_word_s = merge_word(mem_q[idx_q], hwdata_s, byte_strobe(size_q, lo_q));
        rd_idx_s  = accept_s ? new_idx_s : idx_q;
        if (wr_en_s && (rd_idx_s == idx_q)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_q[rd_idx_s];
        end
    end

    // Next-state, transfer capture and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept_s) begin
                    idx_d   = new_idx_s;
                    lo_d    = new_lo_s;
                    size_d  = hsize_s[1:0];
                    write_d = hwrite_s;
                    if (illegal_s) begin
                        state_d = S_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_WAIT:  begin hreadyout_d = 1'b0; hresp_d = 1'b0; end
            S_ERR1:  begin hreadyout_d = 1'b0; hresp_d = 1'b1; end
            S_ERR2:  begin hreadyout_d = 1'b1; hresp_d = 1'b1; end
            default: begin hreadyout_d = 1'b1; hresp_d = 1'b0; end
        endcase

        if ((state_d == S_DATA) && !write_d) begin
            hrdata_d = rd_word_s;
        end else begin
            hrdata_d = 32'h0;
        end
    end

    // Control state and bus outputs
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            lo_q        <= 2'd0;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Storage array, deliberately left out of reset
    always_ff @(posedge hclk) begin
        if (wr_en_s) begin
            mem_q[idx_q] <= wr_word_s;
        end
    end
endmodule
